// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter sharing the single
// uart_tx FIFO between NUM_REQ byte-stream requesters. Once a requester is
// granted it keeps the grant until its byte flagged last has been enqueued,
// so packets never interleave on the wire.
//
// Optional build macro: UART_ARB_WATCHDOG_EN
//   When defined, a requester that drops req_valid mid-packet for
//   TIMEOUT_CYCLES cycles loses the grant and abort pulses for one cycle.
//   When undefined, abort is tied low and a stalled requester holds the
//   grant indefinitely.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per requester: byte available on its lane
//   req_data      flattened lanes, lane i = bits [8i+7:8i]
//   req_last      per requester: current byte ends the packet
//   req_ready     one-cycle accept pulse, coincident with start_uart
//   fifo_ready    uart_tx FIFO can accept a byte
//   start_uart    one-cycle enqueue strobe to uart_tx
//   uart_tx_data  byte to uart_tx, valid while start_uart=1
//   grant_valid   a requester holds the grant
//   grant_idx     index of the granted requester
//   abort         one-cycle pulse on a watchdog grant revocation
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_ready,
  output logic                 start_uart,
  output logic [7:0]           uart_tx_data,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 abort
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr, rr_d, gidx_d, rr_next;
  logic                 gv_d, last_q, last_d, start_d, abort_d;
  logic [7:0]           data_d;
  logic [NUM_REQ-1:0]   ready_d;

  logic [NUM_REQ-1:0][7:0] lane_data;
  assign lane_data = req_data;

  // Round-robin pick: lowest valid index at or above rr_ptr, otherwise wrap
  // to the lowest valid index overall. Descending loops leave the lowest hit.
  logic             hi_found;
  logic [IDX_W-1:0] hi_idx, lo_idx, pick_idx;
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  // Granted-lane mux, written as compares so no index is wider than needed.
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] gnt_oh;
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    gnt_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = lane_data[i];
        gnt_oh[i] = 1'b1;
      end
    end
  end

  assign rr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef UART_ARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt, wd_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    gidx_d  = grant_idx;
    gv_d    = grant_valid;
    rr_d    = rr_ptr;
    last_d  = last_q;
    start_d = 1'b0;
    data_d  = uart_tx_data;
    ready_d = '0;
    abort_d = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
    wd_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gidx_d  = pick_idx;
          gv_d    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fifo_ready && sel_valid) begin
          data_d  = sel_data;
          start_d = 1'b1;
          ready_d = gnt_oh;
          last_d  = sel_last;
          state_d = GAP;
        end
`ifdef UART_ARB_WATCHDOG_EN
        // Only a missing requester is timed out; a full FIFO with valid
        // held high keeps the counter cleared.
        if (sel_valid) begin
          wd_d = '0;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES-1)) begin
          abort_d = 1'b1;
          gv_d    = 1'b0;
          rr_d    = rr_next;
          state_d = IDLE;
        end else begin
          wd_d = wd_cnt + WD_W'(1);
        end
`endif
      end
      GAP: begin
        // One dead cycle lets uart_tx's fifo_ready reflect the last enqueue.
        if (last_q) begin
          gv_d    = 1'b0;
          rr_d    = rr_next;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      rr_ptr       <= '0;
      last_q       <= 1'b0;
      start_uart   <= 1'b0;
      uart_tx_data <= 8'h00;
      req_ready    <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx    <= gidx_d;
      grant_valid  <= gv_d;
      rr_ptr       <= rr_d;
      last_q       <= last_d;
      start_uart   <= start_d;
      uart_tx_data <= data_d;
      req_ready    <= ready_d;
    end
  end

`ifdef UART_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      abort  <= 1'b0;
    end else begin
      wd_cnt <= wd_d;
      abort  <= abort_d;
    end
  end
`else
  assign abort = 1'b0;
  logic unused_abort;
  assign unused_abort = abort_d;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requester models fed from byte
// queues, a log of every enqueued byte with its grant index, and immediate
// assertions at each comparison.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          fifo_ready = 1'b1;
  logic          start_uart;
  logic [7:0]    uart_tx_data;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_ready(fifo_ready),
    .start_uart(start_uart), .uart_tx_data(uart_tx_data),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .abort(abort)
  );

  int total = 0, fails = 0;
  int rdy_err = 0, b2b_err = 0, r0_pulses = 0, abort_seen = 0;
  bit en0, en1, prev_start;
  logic [8:0]  q0[$], q1[$];          // {last, data}
  logic [7:0]  log_d[$];
  logic [IW-1:0] log_s[$];
  logic [10:0] exq[$];                // {src, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid[0]   = en0 && (q0.size() > 0);
    req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req_last[0]    = (q0.size() > 0) && q0[0][8];
    req_valid[1]   = en1 && (q1.size() > 0);
    req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req_last[1]    = (q1.size() > 0) && q1[0][8];
  endtask

  task automatic tick();
    logic [NR-1:0] er;
    @(posedge clk); #1;
    if (start_uart) begin
      log_d.push_back(uart_tx_data);
      log_s.push_back(grant_idx);
      if (prev_start) b2b_err++;
    end
    prev_start = start_uart;
    er = start_uart ? NR'(1 << grant_idx) : '0;
    if (req_ready !== er) rdy_err++;
    if (req_ready[0]) begin r0_pulses++; if (q0.size() > 0) q0.delete(0); end
    if (req_ready[1] && q1.size() > 0) q1.delete(0);
    if (abort) abort_seen++;
    drive();
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !grant_valid) && n < max) begin
      tick(); n++;
    end
    chk({tag, " completes"}, 32'(n < max), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int max);
    int n = 0;
    while (log_d.size() < cnt && n < max) begin tick(); n++; end
    chk({tag, " bytes seen"}, 32'(n < max), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, " count"}, 32'(log_d.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size() && i < log_d.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), {21'd0, log_s[i], log_d[i]}, {21'd0, exq[i]});
  endtask

  task automatic clr_log();
    log_d.delete(); log_s.delete(); exq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " start_uart"}, 32'(start_uart), 0);
    chk({tag, " uart_tx_data"}, 32'(uart_tx_data), 0);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " grant_valid"}, 32'(grant_valid), 0);
    chk({tag, " grant_idx"}, 32'(grant_idx), 0);
    chk({tag, " abort"}, 32'(abort), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    en0 = 0; en1 = 0; drive();
    tick(); tick();
    rst = 0;
    chk_zero("reset");

    // 1: six-byte packet from req0, one byte every other cycle
    clr_log();
    q0 = '{9'h074, 9'h065, 9'h073, 9'h074, 9'h00D, 9'h10A};
    en0 = 1; drive();
    tick();
    chk("t1 grant after 1", 32'(grant_valid), 1);
    chk("t1 no strobe yet", 32'(start_uart), 0);
    tick();
    chk("t1 strobe after 2", 32'(start_uart), 1);
    chk("t1 first byte", 32'(uart_tx_data), 32'h74);
    wait_done("t1", 60);
    exq = '{11'h074, 11'h065, 11'h073, 11'h074, 11'h00D, 11'h00A};
    check_log("t1");
    chk("t1 req_ready0 pulses", 32'(r0_pulses), 6);
    chk("t1 grant dropped", 32'(grant_valid), 0);

    // 2: simultaneous requests after reset, req0 first, then alternating
    rst = 1; en0 = 0; en1 = 0; q0.delete(); q1.delete(); drive();
    tick(); rst = 0; clr_log();
    q0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
    q1 = '{9'h0B0, 9'h1B1};
    en0 = 1; en1 = 1; drive();
    wait_done("t2", 100);
    exq = '{11'h0A0, 11'h0A1, 11'h1B0, 11'h1B1, 11'h0A2, 11'h0A3};
    check_log("t2");

    // 3: req0 arrives while req1 is mid-packet
    clr_log();
    en0 = 0; en1 = 1;
    q1 = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
    drive();
    wait_log("t3", 3, 40);
    q0 = '{9'h0D0, 9'h1D1}; en0 = 1; drive();
    wait_done("t3", 100);
    exq = '{11'h1C0, 11'h1C1, 11'h1C2, 11'h1C3, 11'h1C4, 11'h0D0, 11'h0D1};
    check_log("t3");

    // 4: FIFO full for 50 cycles during SEND
    clr_log();
    en1 = 0; fifo_ready = 0;
    q0 = '{9'h1E0}; en0 = 1; drive();
    repeat (50) tick();
    chk("t4 no strobe while full", 32'(log_d.size()), 0);
    chk("t4 grant held", 32'(grant_valid), 1);
    chk("t4 grant idx", 32'(grant_idx), 0);
    fifo_ready = 1;
    tick();
    chk("t4 strobe after ready", 32'(start_uart), 1);
    chk("t4 byte", 32'(uart_tx_data), 32'hE0);
    wait_done("t4", 20);
    chk("t4 enqueued once", 32'(log_d.size()), 1);

    // 5: reset after byte 2 of 5; rr_ptr is 1 before reset
    clr_log();
    q0 = '{9'h0F0, 9'h0F1, 9'h0F2, 9'h0F3, 9'h1F4}; en0 = 1; drive();
    wait_log("t5", 2, 20);
    rst = 1;
    tick();
    chk_zero("t5 mid reset");
    rst = 0; clr_log();
    q0.delete(); q1.delete();
    q0 = '{9'h1E5}; q1 = '{9'h1E6};
    en0 = 1; en1 = 1; drive();
    tick();
    chk("t5 grant after reset", 32'(grant_valid), 1);
    chk("t5 rr restarts at 0", 32'(grant_idx), 0);
    wait_done("t5", 40);
    exq = '{11'h0E5, 11'h1E6};
    check_log("t5");

    // 6: req0 drops valid mid-packet while req1 waits
    clr_log();
    q0 = '{9'h030, 9'h031, 9'h132}; q1 = '{9'h140};
    en0 = 1; en1 = 0; drive();
    wait_log("t6", 1, 20);
    en0 = 0; en1 = 1; drive();
    abort_seen = 0;
`ifdef UART_ARB_WATCHDOG_EN
    begin
      int n = 0;
      while (!abort && n < 30) begin tick(); n++; end
      chk("t6 abort fired", 32'(abort), 1);
      chk("t6 abort timing", 32'(n >= 16 && n <= 18), 1);
      chk("t6 grant revoked", 32'(grant_valid), 0);
      tick();
      chk("t6 abort one cycle", 32'(abort), 0);
      chk("t6 req1 granted", 32'(grant_idx), 1);
      q0.delete();
      wait_done("t6", 40);
      exq = '{11'h030, 11'h140};
      check_log("t6");
    end
`else
    repeat (40) tick();
    chk("t6 abort never", 32'(abort_seen), 0);
    chk("t6 grant held", 32'(grant_valid), 1);
    chk("t6 grant idx", 32'(grant_idx), 0);
    chk("t6 no extra bytes", 32'(log_d.size()), 1);
    en0 = 1; drive();
    wait_done("t6", 60);
    exq = '{11'h030, 11'h031, 11'h032, 11'h140};
    check_log("t6");
`endif

    chk("strobe spacing", 32'(b2b_err), 0);
    chk("req_ready matches strobe", 32'(rdy_err), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmit FIFO between NUM_REQ byte-stream requesters, for example the periodic string sender and the SPI-to-UART echo path. Round-robin arbitration is performed at packet granularity. The grant is held until the requester's byte flagged last has been enqueued, so packets never interleave. This block is the only driver of uart_tx's start_uart and uart_tx_data, sequencing each enqueue as a one-cycle pulse gated by fifo_ready.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDX_W, 3, width of grant index; must satisfy 2^IDX_W >= NUM_REQ
TIMEOUT_CYCLES, 2700000, mid-packet stall limit in clk cycles (100 ms at 27 MHz); used only with the optional feature

Ports:
clk  in  1  system clock (27 MHz)
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester: byte available on its req_data lane
req_data  in  NUM_REQ*8  flattened bytes; lane i = bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester: current byte ends the packet
req_ready  out  NUM_REQ  one-cycle accept pulse to the requester whose byte was enqueued
fifo_ready  in  1  from uart_tx: FIFO can accept a byte
start_uart  out  1  to uart_tx: one-cycle enqueue strobe
uart_tx_data  out  8  to uart_tx: byte, valid while start_uart=1
grant_valid  out  1  a requester holds the grant
grant_idx  out  IDX_W  index of the granted requester
abort  out  1  one-cycle pulse when a grant is revoked by timeout (optional feature only)

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: start_uart=0, uart_tx_data=0, req_ready=0, grant_valid=0, grant_idx=0, abort=0, rr_ptr=0, state=IDLE.
- Handshake: a byte transfers when req_ready[i]=1. req_ready[i] is asserted in the same cycle as start_uart. A requester must hold req_valid/req_data/req_last stable until it sees req_ready. Dropping req_valid before req_ready is legal and means no transfer.
- States:
  - IDLE: if any req_valid bit is set, pick the first set bit searching upward from rr_ptr and wrapping modulo NUM_REQ. Set grant_idx to it and grant_valid=1, then go to SEND. If none are set, stay in IDLE.
  - SEND: if fifo_ready=1 and req_valid[grant_idx]=1, register uart_tx_data=lane data, start_uart=1, req_ready[grant_idx]=1, latch last_q=req_last[grant_idx], and go to GAP. Otherwise wait in SEND, holding the grant.
  - GAP: exactly one cycle. start_uart and req_ready return to 0; this absorbs the uart_tx fifo_ready update latency. If last_q=1, set grant_valid=0, rr_ptr=(grant_idx+1) mod NUM_REQ, and go to IDLE. Otherwise go to SEND.
- Latency: valid in IDLE at cycle N gives grant at N+1 and start_uart at N+2, if fifo_ready. Sustained throughput is at most 1 byte per 2 cycles.
- Arbitration fairness: rr_ptr advances only when a packet completes. A requester that is continuously valid waits at most NUM_REQ-1 packets.
- Simultaneous events: requests arriving during SEND or GAP are ignored until IDLE. A single-byte packet (req_last set on the first byte) is legal.
- fifo_ready low: SEND stalls indefinitely; no byte is dropped and no strobe is issued.
- Reset mid-packet: everything returns to reset values on the next edge. The partial packet is abandoned, and the requester must restart it.
- Out-of-range grant_idx (NUM_REQ not a power of two) is never produced.

Optional Feature:
UART_ARB_WATCHDOG_EN
- Defined:
  - A counter runs while in SEND with req_valid[grant_idx]=0; it clears whenever the byte is accepted or valid is high.
  - When the counter reaches TIMEOUT_CYCLES-1, the block pulses abort for 1 cycle, sets grant_valid=0, advances rr_ptr past grant_idx, and goes to IDLE.
  - A stall on fifo_ready=0 is never timed out.
- Undefined: no counter is present; abort is tied to 0. A stalled requester holds the grant indefinitely.

Test Plan:
1. Req0 sends a 6-byte packet "test",0D,0A with fifo_ready=1. Required: 6 start_uart pulses, each followed by a low cycle, carrying bytes 74 65 73 74 0D 0A; 6 req_ready[0] pulses; grant_valid drops after byte 0A.
2. Req0 and req1 become valid in the same cycle after reset. Required: req0 is granted first. After req0's last byte, req1 is granted; then req0 is granted again if still valid.
3. Req1 is mid-packet (3 bytes sent) when req0 asserts. Required: no req0 byte appears until req1's last byte; the uart_tx_data sequence is not interleaved.
4. fifo_ready is held low for 50 cycles during SEND. Required: start_uart stays 0 throughout; the byte is enqueued exactly once, 1 cycle after fifo_ready rises.
5. rst is asserted for one cycle after byte 2 of 5. Required: all outputs are 0 on the next cycle and the state is IDLE; the next grant follows the rr_ptr=0 order.
6. With UART_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16, req0 drops valid mid-packet while req1 is waiting. Required: abort pulses 16 cycles later, then req1 is granted. Without the macro, req0 holds the grant and abort stays 0.
